// File: rtl/lpc_frame_arbiter_if.sv
// Bundle of per-source AXI-Stream inputs, the merged encoder stream and grant/error status
// for lpc_frame_arbiter. The slave view is the arbiter; the master view is the surrounding system.
interface lpc_frame_arbiter_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 16,
   parameter int ID_W   = 2
);
   logic [N_CH-1:0]        S_TVALID;
   logic [N_CH-1:0]        S_TREADY;
   logic [N_CH*DATA_W-1:0] S_TDATA;
   logic [N_CH-1:0]        S_TLAST;
   logic                   M_TVALID;
   logic                   M_TREADY;
   logic [DATA_W-1:0]      M_TDATA;
   logic                   M_TLAST;
   logic                   GRANT_VALID;
   logic [ID_W-1:0]        GRANT_ID;
   logic [N_CH-1:0]        ERR;
   logic [N_CH-1:0]        ERR_CLR;

   modport slave (
      input  S_TVALID, S_TDATA, S_TLAST, M_TREADY, ERR_CLR,
      output S_TREADY, M_TVALID, M_TDATA, M_TLAST, GRANT_VALID, GRANT_ID, ERR
   );

   modport master (
      output S_TVALID, S_TDATA, S_TLAST, M_TREADY, ERR_CLR,
      input  S_TREADY, M_TVALID, M_TDATA, M_TLAST, GRANT_VALID, GRANT_ID, ERR
   );
endinterface

// File: rtl/lpc_frame_arbiter.sv
// Frame-granular round-robin arbiter: one source owns the encoder stream until TLAST,
// frames longer than MAX_FRAME are cut with a forced TLAST and their tail is drained.
module lpc_frame_arbiter #(
   parameter int N_CH      = 4,
   parameter int DATA_W    = 16,
   parameter int ID_W      = 2,
   parameter int MAX_FRAME = 160
) (
   input logic                ACLK,
   input logic                ARESET_N,
   lpc_frame_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [15:0] LAST_CNT = 16'(MAX_FRAME - 1);

   state_t            state_r;
   state_t            state_s;
   logic [ID_W-1:0]   ptr_r;
   logic [ID_W-1:0]   ptr_s;
   logic [ID_W-1:0]   grant_id_r;
   logic [ID_W-1:0]   grant_id_s;
   logic [ID_W-1:0]   pick_s;
   logic              grant_valid_r;
   logic              grant_valid_s;
   logic              found_s;
   logic [15:0]       cnt_r;
   logic [15:0]       cnt_s;
   logic [N_CH-1:0]   err_r;
   logic [N_CH-1:0]   err_s;
   logic [N_CH-1:0]   err_set_s;
   logic [N_CH-1:0]   grant_oh_s;
   logic              sel_valid_s;
   logic              sel_last_s;
   logic              beat_s;
   logic              at_limit_s;
   logic [DATA_W-1:0] sel_data_s;

   // One-hot of the granted channel and the stream it selects
   always_comb begin
      grant_oh_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         grant_oh_s[i] = (grant_id_r == ID_W'(i));
         sel_data_s    = sel_data_s | (bus.S_TDATA[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_s[i]}});
      end
      sel_valid_s = |(bus.S_TVALID & grant_oh_s);
      sel_last_s  = |(bus.S_TLAST & grant_oh_s);
   end

   // Round-robin pick: first requester scanning ptr+1, ptr+2, ... modulo N_CH
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      for (int k = 1; k <= N_CH; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (!found_s && bus.S_TVALID[i] && (i == (int'(ptr_r) + k) % N_CH)) begin
               found_s = 1'b1;
               pick_s  = ID_W'(i);
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   assign at_limit_s = (cnt_r == LAST_CNT);
   assign beat_s     = sel_valid_s & (((state_r == ST_PASS) & bus.M_TREADY) | (state_r == ST_DROP));

   // Next-state, grant bookkeeping and sticky error update
   always_comb begin
      state_s       = state_r;
      ptr_s         = ptr_r;
      grant_id_s    = grant_id_r;
      grant_valid_s = grant_valid_r;
      cnt_s         = cnt_r;
      err_set_s     = '0;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s       = ST_PASS;
               grant_id_s    = pick_s;
               grant_valid_s = 1'b1;
               cnt_s         = 16'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PASS: begin
            if (beat_s) begin
               cnt_s = cnt_r + 16'd1;
               if (sel_last_s) begin
                  state_s       = ST_IDLE;
                  ptr_s         = grant_id_r;
                  grant_valid_s = 1'b0;
               end else if (at_limit_s) begin
                  // Source TLAST on the limit beat takes the branch above: normal end, no error
                  err_set_s = grant_oh_s;
                  state_s   = ST_DROP;
               end else begin
                  state_s = ST_PASS;
               end
            end else begin
               state_s = ST_PASS;
            end
         end
         ST_DROP: begin
            if (beat_s && sel_last_s) begin
               state_s       = ST_IDLE;
               ptr_s         = grant_id_r;
               grant_valid_s = 1'b0;
            end else begin
               state_s = ST_DROP;
            end
         end
         default: begin
            state_s       = ST_IDLE;
            grant_valid_s = 1'b0;
         end
      endcase
      err_s = (err_r & ~bus.ERR_CLR) | err_set_s;
   end

   // State and status registers with synchronous active-low reset
   always_ff @(posedge ACLK) begin
      if (!ARESET_N) begin
         state_r       <= ST_IDLE;
         ptr_r         <= ID_W'(N_CH - 1);
         grant_id_r    <= '0;
         grant_valid_r <= 1'b0;
         cnt_r         <= 16'd0;
         err_r         <= '0;
      end else begin
         state_r       <= state_s;
         ptr_r         <= ptr_s;
         grant_id_r    <= grant_id_s;
         grant_valid_r <= grant_valid_s;
         cnt_r         <= cnt_s;
         err_r         <= err_s;
      end
   end

   // Zero-latency passthrough in PASS, sink-only in DROP, quiet in IDLE
   always_comb begin
      bus.M_TVALID = 1'b0;
      bus.M_TDATA  = '0;
      bus.M_TLAST  = 1'b0;
      bus.S_TREADY = '0;
      case (state_r)
         ST_PASS: begin
            bus.M_TVALID = sel_valid_s;
            bus.M_TDATA  = sel_data_s;
            bus.M_TLAST  = sel_last_s | at_limit_s;
            bus.S_TREADY = grant_oh_s & {N_CH{bus.M_TREADY}};
         end
         ST_DROP: begin
            bus.S_TREADY = grant_oh_s;
         end
         default: begin
            bus.S_TREADY = '0;
         end
      endcase
   end

   assign bus.GRANT_VALID = grant_valid_r;
   assign bus.GRANT_ID    = grant_id_r;
   assign bus.ERR         = err_r;
endmodule
